// File: rtl/vector_lane_sequencer.sv
// vector_lane_sequencer
//   Issue side of the vector lane interface. Takes one whole-register vector
//   op from dispatch, splits it into beats of NUM_LANES elements, drives the
//   lanes one beat per cycle, gathers the lane results back into a packed vd
//   and hands vd out on a valid/ready response port.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   flush              synchronous squash of whatever op is in flight
//   req_*              op request (valid/ready, vs1, vs2, op code, vl, tag)
//   lane_op1/op2       per-lane operands, lane i at [i*ELEN +: ELEN]
//   lane_vec_op        op code shared by all lanes
//   lane_valid_in      per-lane issue strobe
//   lane_result        per-lane results
//   lane_valid_out     per-lane result strobe, one cycle after lane_valid_in
//   resp_*             response (valid/ready, packed vd, tag, clamped vl)
module vector_lane_sequencer #(
  parameter int ELEN      = 32,
  parameter int NUM_LANES = 4,
  parameter int VLEN      = 256,
  localparam int MAX_ELEMS = VLEN / ELEN,
  localparam int VLW       = $clog2(MAX_ELEMS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [VLEN-1:0]           req_vs1,
  input  logic [VLEN-1:0]           req_vs2,
  input  logic [3:0]                req_vec_op,
  input  logic [VLW-1:0]            req_vl,
  input  logic [5:0]                req_tag,
  output logic [NUM_LANES*ELEN-1:0] lane_op1,
  output logic [NUM_LANES*ELEN-1:0] lane_op2,
  output logic [3:0]                lane_vec_op,
  output logic [NUM_LANES-1:0]      lane_valid_in,
  input  logic [NUM_LANES*ELEN-1:0] lane_result,
  input  logic [NUM_LANES-1:0]      lane_valid_out,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [VLEN-1:0]           resp_vd,
  output logic [5:0]                resp_tag,
  output logic [VLW-1:0]            resp_vl
);

  localparam int MAX_BEATS = MAX_ELEMS / NUM_LANES;
  localparam int BW        = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                      state;
  logic [VLEN-1:0]             vs1_q;
  logic [VLEN-1:0]             vs2_q;
  logic [VLW-1:0]              collected_q;
  logic [BW-1:0]               beats_q;
  logic [BW-1:0]               issue_beat_q;
  logic [BW-1:0]               collect_beat_q;

  logic [VLW-1:0]              vl_clamped;
  logic [BW-1:0]               req_beats;
  logic [VLEN-1:0]             src_vs1;
  logic [VLEN-1:0]             src_vs2;
  int                          src_vl;
  int                          src_beat;
  logic [NUM_LANES*ELEN-1:0]   beat_op1;
  logic [NUM_LANES*ELEN-1:0]   beat_op2;
  logic [NUM_LANES-1:0]        beat_valid;
  logic [VLW-1:0]              pop_cnt;
  logic [VLW-1:0]              collected_next;
  logic                        collecting;

  always_comb begin
    vl_clamped = (int'(req_vl) > MAX_ELEMS) ? VLW'(MAX_ELEMS) : req_vl;
    req_beats  = BW'((int'(vl_clamped) + NUM_LANES - 1) / NUM_LANES);
  end

  // One beat builder serves both the accept edge (beat 0 straight from the
  // request so it is on the lanes the cycle after accept) and later beats
  // from the captured operands.
  always_comb begin
    beat_op1   = '0;
    beat_op2   = '0;
    beat_valid = '0;
    if (state == IDLE) begin
      src_vs1  = req_vs1;
      src_vs2  = req_vs2;
      src_vl   = int'(vl_clamped);
      src_beat = 0;
    end else begin
      src_vs1  = vs1_q;
      src_vs2  = vs2_q;
      src_vl   = int'(resp_vl);
      src_beat = int'(issue_beat_q);
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if (src_beat * NUM_LANES + i < MAX_ELEMS) begin
        beat_op1[i*ELEN +: ELEN] = src_vs1[(src_beat * NUM_LANES + i) * ELEN +: ELEN];
        beat_op2[i*ELEN +: ELEN] = src_vs2[(src_beat * NUM_LANES + i) * ELEN +: ELEN];
        beat_valid[i]            = (src_beat * NUM_LANES + i < src_vl);
      end
    end
  end

  // Results only count while an op is actually outstanding; strobes that
  // arrive after a flush land in IDLE and are dropped here.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pop_cnt = pop_cnt + VLW'(lane_valid_out[i]);
    end
    collecting     = (state == ISSUE) || (state == WAIT);
    collected_next = collected_q + pop_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      vs1_q          <= '0;
      vs2_q          <= '0;
      collected_q    <= '0;
      beats_q        <= '0;
      issue_beat_q   <= '0;
      collect_beat_q <= '0;
      req_ready      <= 1'b1;
      lane_op1       <= '0;
      lane_op2       <= '0;
      lane_vec_op    <= '0;
      lane_valid_in  <= '0;
      resp_valid     <= 1'b0;
      resp_vd        <= '0;
      resp_tag       <= '0;
      resp_vl        <= '0;
    end else if (flush) begin
      state         <= IDLE;
      lane_valid_in <= '0;
      resp_valid    <= 1'b0;
      req_ready     <= 1'b1;
    end else begin
      // A beat's results share one collect index, so lane i of collect beat
      // cb always lands in element cb*NUM_LANES+i.
      if (collecting && (lane_valid_out != '0)) begin
        collect_beat_q <= collect_beat_q + 1'b1;
        collected_q    <= collected_next;
        for (int i = 0; i < NUM_LANES; i++) begin
          if (lane_valid_out[i] &&
              (int'(collect_beat_q) * NUM_LANES + i < MAX_ELEMS)) begin
            resp_vd[(int'(collect_beat_q) * NUM_LANES + i) * ELEN +: ELEN]
              <= lane_result[i*ELEN +: ELEN];
          end
        end
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            vs1_q          <= req_vs1;
            vs2_q          <= req_vs2;
            lane_vec_op    <= req_vec_op;
            resp_tag       <= req_tag;
            resp_vl        <= vl_clamped;
            beats_q        <= req_beats;
            resp_vd        <= '0;
            collected_q    <= '0;
            collect_beat_q <= '0;
            req_ready      <= 1'b0;
            if (vl_clamped == '0) begin
              state      <= DONE;
              resp_valid <= 1'b1;
            end else begin
              state         <= ISSUE;
              lane_op1      <= beat_op1;
              lane_op2      <= beat_op2;
              lane_valid_in <= beat_valid;
              issue_beat_q  <= BW'(1);
            end
          end
        end
        ISSUE: begin
          if (issue_beat_q == beats_q) begin
            lane_valid_in <= '0;
            state         <= WAIT;
          end else begin
            lane_op1      <= beat_op1;
            lane_op2      <= beat_op2;
            lane_valid_in <= beat_valid;
            issue_beat_q  <= issue_beat_q + 1'b1;
          end
        end
        WAIT: begin
          if (collected_next == resp_vl) begin
            state      <= DONE;
            resp_valid <= 1'b1;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// tb_vector_lane_sequencer
//   Directed bench for vector_lane_sequencer: a registered lane model answers
//   every issue strobe one cycle later, a table of ops is run and compared
//   against hand-computed masks/latency plus a bench-computed vd, and a few
//   hand-written sequences cover reset mid-op, response backpressure and flush.
module tb_vector_lane_sequencer;

  localparam int ELEN      = 32;
  localparam int NUM_LANES = 4;
  localparam int VLEN      = 256;
  localparam int MAX_ELEMS = 8;
  localparam int VLW       = 4;

  logic                      clk;
  logic                      rst_n;
  logic                      flush;
  logic                      req_valid;
  logic                      req_ready;
  logic [VLEN-1:0]           req_vs1;
  logic [VLEN-1:0]           req_vs2;
  logic [3:0]                req_vec_op;
  logic [VLW-1:0]            req_vl;
  logic [5:0]                req_tag;
  logic [NUM_LANES*ELEN-1:0] lane_op1;
  logic [NUM_LANES*ELEN-1:0] lane_op2;
  logic [3:0]                lane_vec_op;
  logic [NUM_LANES-1:0]      lane_valid_in;
  logic [NUM_LANES*ELEN-1:0] lane_result;
  logic [NUM_LANES-1:0]      lane_valid_out;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [VLEN-1:0]           resp_vd;
  logic [5:0]                resp_tag;
  logic [VLW-1:0]            resp_vl;

  int errors = 0;
  int checks = 0;

  vector_lane_sequencer #(
    .ELEN(ELEN), .NUM_LANES(NUM_LANES), .VLEN(VLEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vs1(req_vs1), .req_vs2(req_vs2), .req_vec_op(req_vec_op),
    .req_vl(req_vl), .req_tag(req_tag),
    .lane_op1(lane_op1), .lane_op2(lane_op2), .lane_vec_op(lane_vec_op),
    .lane_valid_in(lane_valid_in), .lane_result(lane_result),
    .lane_valid_out(lane_valid_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_vd(resp_vd), .resp_tag(resp_tag), .resp_vl(resp_vl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-local op encoding: 0 add, 1 sub, 2 xor, 3 and.
  function automatic logic [ELEN-1:0] lane_fn(input logic [3:0] op,
                                              input logic [ELEN-1:0] a,
                                              input logic [ELEN-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a ^ b;
      default: return a & b;
    endcase
  endfunction

  // Lane model: one-cycle registered lanes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_valid_out <= '0;
      lane_result    <= '0;
    end else begin
      lane_valid_out <= lane_valid_in;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_result[i*ELEN +: ELEN] <= lane_fn(lane_vec_op,
                                               lane_op1[i*ELEN +: ELEN],
                                               lane_op2[i*ELEN +: ELEN]);
      end
    end
  end

  function automatic logic [VLEN-1:0] make_vec(input logic [31:0] base,
                                               input logic [31:0] stride);
    logic [VLEN-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_ELEMS; i++) v[i*ELEN +: ELEN] = base + stride * i;
    return v;
  endfunction

  function automatic logic [VLEN-1:0] expect_vd(input logic [3:0] op,
                                                input logic [VLEN-1:0] a,
                                                input logic [VLEN-1:0] b,
                                                input int vl_eff);
    logic [VLEN-1:0] v;
    v = '0;
    for (int i = 0; i < vl_eff; i++)
      v[i*ELEN +: ELEN] = lane_fn(op, a[i*ELEN +: ELEN], b[i*ELEN +: ELEN]);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [VLEN-1:0] actual,
                             input logic [VLEN-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one op to completion and reports what the DUT did with it.
  task automatic applyStimulus(input logic [VLW-1:0] vl, input logic [5:0] tag,
                               input logic [3:0] op, input logic [VLEN-1:0] a,
                               input logic [VLEN-1:0] b, output int latency,
                               output logic [3:0] m0, output logic [3:0] m1,
                               output logic [VLEN-1:0] vd, output logic [5:0] rtag,
                               output logic [VLW-1:0] rvl);
    int w;
    w = 0;
    while (!req_ready && w < 40) begin
      step();
      w++;
    end
    checkOutput("req_ready before accept", VLEN'(req_ready), VLEN'(1));
    req_vs1 = a; req_vs2 = b; req_vec_op = op; req_vl = vl; req_tag = tag;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    latency = 1;
    m0 = lane_valid_in;
    m1 = '0;
    while (!resp_valid && latency < 40) begin
      step();
      latency++;
      if (latency == 2) m1 = lane_valid_in;
    end
    vd = resp_vd; rtag = resp_tag; rvl = resp_vl;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  typedef struct {
    logic [VLW-1:0] vl;
    logic [5:0]     tag;
    logic [3:0]     op;
    logic [31:0]    base1, stride1, base2, stride2;
    int             exp_lat;
    logic [3:0]     exp_m0, exp_m1;
    logic [VLW-1:0] exp_vl;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat, bad;
    logic [3:0] m0, m1;
    logic [VLEN-1:0] vd, snap_vd, a, b;
    logic [5:0] rtag;
    logic [VLW-1:0] rvl;

    vecs[0] = '{4'd8,  6'd5,  4'd0, 32'd0,   32'd1, 32'd0,    32'd10, 4, 4'hF, 4'hF, 4'd8};
    vecs[1] = '{4'd5,  6'd9,  4'd1, 32'd100, 32'd3, 32'd7,    32'd2,  4, 4'hF, 4'h1, 4'd5};
    vecs[2] = '{4'd0,  6'd3,  4'd0, 32'd1,   32'd1, 32'd1,    32'd1,  1, 4'h0, 4'h0, 4'd0};
    vecs[3] = '{4'd12, 6'd63, 4'd2, 32'hA5,  32'd9, 32'h5A00, 32'd17, 4, 4'hF, 4'hF, 4'd8};
    vecs[4] = '{4'd3,  6'd1,  4'd3, 32'hFF0, 32'd5, 32'h0FF,  32'd33, 3, 4'h7, 4'h0, 4'd3};
    vecs[5] = '{4'd4,  6'd42, 4'd0, 32'd7,   32'd7, 32'd1000, 32'd1,  3, 4'hF, 4'h0, 4'd4};
    vecs[6] = '{4'd15, 6'd20, 4'd1, 32'd0,   32'd0, 32'd1,    32'd1,  4, 4'hF, 4'hF, 4'd8};

    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_vs1 = '0; req_vs2 = '0; req_vec_op = '0; req_vl = '0; req_tag = '0;
    step(); step();
    checkOutput("reset req_ready", VLEN'(req_ready), VLEN'(1));
    checkOutput("reset resp_valid", VLEN'(resp_valid), '0);
    checkOutput("reset lane_valid_in", VLEN'(lane_valid_in), '0);
    checkOutput("reset resp_vd", resp_vd, '0);
    checkOutput("reset lane_op1", VLEN'(lane_op1), '0);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 7; k++) begin
      a = make_vec(vecs[k].base1, vecs[k].stride1);
      b = make_vec(vecs[k].base2, vecs[k].stride2);
      applyStimulus(vecs[k].vl, vecs[k].tag, vecs[k].op, a, b, lat, m0, m1, vd, rtag, rvl);
      checkOutput($sformatf("vec%0d latency", k), VLEN'(lat), VLEN'(vecs[k].exp_lat));
      checkOutput($sformatf("vec%0d beat0 mask", k), VLEN'(m0), VLEN'(vecs[k].exp_m0));
      checkOutput($sformatf("vec%0d beat1 mask", k), VLEN'(m1), VLEN'(vecs[k].exp_m1));
      checkOutput($sformatf("vec%0d resp_vd", k), vd,
                  expect_vd(vecs[k].op, a, b, int'(vecs[k].exp_vl)));
      checkOutput($sformatf("vec%0d resp_tag", k), VLEN'(rtag), VLEN'(vecs[k].tag));
      checkOutput($sformatf("vec%0d resp_vl", k), VLEN'(rvl), VLEN'(vecs[k].exp_vl));
    end

    // Reset asserted while the op is in ISSUE: dropped, no response.
    req_vs1 = make_vec(32'd1, 32'd1); req_vs2 = make_vec(32'd2, 32'd2);
    req_vec_op = 4'd0; req_vl = 4'd8; req_tag = 6'd11; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    checkOutput("midop issuing", VLEN'(lane_valid_in), VLEN'(4'hF));
    rst_n = 1'b0;
    #1;
    checkOutput("midop rst lane_valid_in", VLEN'(lane_valid_in), '0);
    checkOutput("midop rst resp_valid", VLEN'(resp_valid), '0);
    checkOutput("midop rst req_ready", VLEN'(req_ready), VLEN'(1));
    step();
    checkOutput("midop rst held lane_valid_in", VLEN'(lane_valid_in), '0);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (resp_valid || lane_valid_in != '0) bad++;
    end
    checkOutput("midop rst no response", VLEN'(bad), '0);

    // Response backpressure: DONE holds, new requests ignored.
    a = make_vec(32'd3, 32'd4); b = make_vec(32'd50, 32'd6);
    req_vs1 = a; req_vs2 = b; req_vec_op = 4'd2; req_vl = 4'd8; req_tag = 6'd7;
    req_valid = 1'b1;
    step();
    req_vs1 = make_vec(32'hDEAD, 32'd1); req_tag = 6'd33;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      step();
      lat++;
    end
    checkOutput("bp latency", VLEN'(lat), VLEN'(4));
    snap_vd = expect_vd(4'd2, a, b, 8);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (!resp_valid || resp_vd !== snap_vd || resp_tag != 6'd7 || req_ready) bad++;
      step();
    end
    checkOutput("bp hold cycles bad", VLEN'(bad), '0);
    checkOutput("bp resp_vd", resp_vd, snap_vd);
    checkOutput("bp req_ready low", VLEN'(req_ready), '0);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    checkOutput("bp release req_ready", VLEN'(req_ready), VLEN'(1));
    checkOutput("bp release resp_valid", VLEN'(resp_valid), '0);
    a = make_vec(32'd9, 32'd9); b = make_vec(32'd1, 32'd0);
    applyStimulus(4'd6, 6'd12, 4'd0, a, b, lat, m0, m1, vd, rtag, rvl);
    checkOutput("bp next vd", vd, expect_vd(4'd0, a, b, 6));
    checkOutput("bp next tag", VLEN'(rtag), VLEN'(12));

    // Flush in the first ISSUE cycle, then a new op straight away while
    // the stale beat-0 strobes are still coming back.
    req_vs1 = make_vec(32'd77, 32'd1); req_vs2 = make_vec(32'd5, 32'd5);
    req_vec_op = 4'd0; req_vl = 4'd8; req_tag = 6'd2; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush lane_valid_in", VLEN'(lane_valid_in), '0);
    checkOutput("flush resp_valid", VLEN'(resp_valid), '0);
    checkOutput("flush req_ready", VLEN'(req_ready), VLEN'(1));
    checkOutput("flush stale strobes present", VLEN'(lane_valid_out), VLEN'(4'hF));
    a = make_vec(32'd4, 32'd2); b = make_vec(32'd40, 32'd3);
    applyStimulus(4'd4, 6'd19, 4'd0, a, b, lat, m0, m1, vd, rtag, rvl);
    checkOutput("flush next latency", VLEN'(lat), VLEN'(3));
    checkOutput("flush next vd", vd, expect_vd(4'd0, a, b, 4));
    checkOutput("flush next tag", VLEN'(rtag), VLEN'(19));

    // Flush wins over a same-cycle accept.
    req_vl = 4'd8; req_tag = 6'd44; req_valid = 1'b1; flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    checkOutput("flush+accept req_ready", VLEN'(req_ready), VLEN'(1));
    checkOutput("flush+accept lane_valid_in", VLEN'(lane_valid_in), '0);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (resp_valid || lane_valid_in != '0) bad++;
    end
    checkOutput("flush+accept no activity", VLEN'(bad), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
